// File: rtl/x_sram_pkg.sv
// Shared definitions for the SRAM lane response path.
// Provides the lane count, the lane index width, the default fill byte and
// the response-collector state type.
package x_sram_pkg;

  localparam int unsigned N_LANES      = 16;
  localparam int unsigned LANE_IDX_W   = 4;
  localparam int unsigned BYTE_W       = 8;
  localparam logic [7:0]  FILL_DEFAULT = 8'hEE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } rsp_state_t;

endpackage

// File: rtl/x_lsb_find16.sv
// Lowest-set-bit encoder over 16 bits.
// Ports:
//   i_vec   : input vector, bit n is lane n
//   o_idx_c : index of the lowest set bit (0 when i_vec is zero)
//   o_any_c : high when any bit of i_vec is set
module x_lsb_find16
  import x_sram_pkg::*;
(
  input  logic [N_LANES-1:0]    i_vec,
  output logic [LANE_IDX_W-1:0] o_idx_c,
  output logic                  o_any_c
);

  // Scan from the top so the lowest set bit is written last and wins.
  always_comb begin
    o_idx_c = '0;
    o_any_c = |i_vec;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx_c = LANE_IDX_W'(i);
    end
  end

endmodule

// File: rtl/x_rsp_collect.sv
// Collects read bytes from the 16 SRAM data lanes named in an issued lane
// mask, waits for all of them (or a timeout), then streams them to the UART
// transmitter in ascending lane order over a valid/accept handshake.
// Ports:
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   i_issue, i_mask         : read launch pulse and the lanes expected to answer
//   i_ready, i_rdata_0..F   : per-lane read strobe and read byte
//   o_valid, o_data         : byte offered to the transmitter
//   i_accept                : transmitter takes o_data this cycle
//   o_busy                  : high outside IDLE
//   o_done                  : one-cycle pulse after the last byte is accepted
//   o_overrun, o_timeout    : sticky protocol-error / lane-filled flags
module x_rsp_collect
  import x_sram_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096,
  parameter logic [7:0]  FILL    = FILL_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_issue,
  input  logic [N_LANES-1:0] i_mask,
  input  logic [N_LANES-1:0] i_ready,
  input  logic [7:0]         i_rdata_0,
  input  logic [7:0]         i_rdata_1,
  input  logic [7:0]         i_rdata_2,
  input  logic [7:0]         i_rdata_3,
  input  logic [7:0]         i_rdata_4,
  input  logic [7:0]         i_rdata_5,
  input  logic [7:0]         i_rdata_6,
  input  logic [7:0]         i_rdata_7,
  input  logic [7:0]         i_rdata_8,
  input  logic [7:0]         i_rdata_9,
  input  logic [7:0]         i_rdata_A,
  input  logic [7:0]         i_rdata_B,
  input  logic [7:0]         i_rdata_C,
  input  logic [7:0]         i_rdata_D,
  input  logic [7:0]         i_rdata_E,
  input  logic [7:0]         i_rdata_F,
  output logic               o_valid,
  output logic [7:0]         o_data,
  input  logic               i_accept,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overrun,
  output logic               o_timeout
);

  // Last counter value of the COLLECT window; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [7:0] rdata [N_LANES];

  assign rdata[0]  = i_rdata_0;
  assign rdata[1]  = i_rdata_1;
  assign rdata[2]  = i_rdata_2;
  assign rdata[3]  = i_rdata_3;
  assign rdata[4]  = i_rdata_4;
  assign rdata[5]  = i_rdata_5;
  assign rdata[6]  = i_rdata_6;
  assign rdata[7]  = i_rdata_7;
  assign rdata[8]  = i_rdata_8;
  assign rdata[9]  = i_rdata_9;
  assign rdata[10] = i_rdata_A;
  assign rdata[11] = i_rdata_B;
  assign rdata[12] = i_rdata_C;
  assign rdata[13] = i_rdata_D;
  assign rdata[14] = i_rdata_E;
  assign rdata[15] = i_rdata_F;

  rsp_state_t            state_q, state_d;
  logic [N_LANES-1:0]    mask_q, mask_d;
  logic [N_LANES-1:0]    got_q, got_d;
  logic [N_LANES-1:0]    pend_q, pend_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LANE_IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]            lane_buf_q [N_LANES];
  logic [7:0]            lane_buf_d [N_LANES];
  logic                  valid_q, valid_d;
  logic [7:0]            data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;
  logic [N_LANES-1:0]    cap;
  logic                  pend_any;

  // Next lane to send is always the lowest bit still pending.
  x_lsb_find16 u_lsb (
    .i_vec   (pend_d),
    .o_idx_c (ptr_d),
    .o_any_c (pend_any)
  );

  // State, capture and pending-set update.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    got_d      = got_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    lane_buf_d = lane_buf_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    cap        = '0;

    unique case (state_q)
      IDLE: begin
        if (i_issue && (i_mask != '0)) begin
          mask_d    = i_mask;
          got_d     = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = COLLECT;
        end
      end

      COLLECT: begin
        if (i_issue) overrun_d = 1'b1;
        // First byte per expected lane wins; anything else is a protocol error.
        cap = i_ready & mask_q & ~got_q;
        if ((i_ready & ~cap) != '0) overrun_d = 1'b1;
        for (int n = 0; n < N_LANES; n++) begin
          if (cap[n]) lane_buf_d[n] = rdata[n];
        end
        got_d = got_q | cap;
        cnt_d = cnt_q + CNT_W'(1);
        if ((got_d & mask_q) == mask_q) begin
          pend_d  = mask_q;
          state_d = SEND;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          pend_d    = mask_q;
          timeout_d = 1'b1;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (i_issue) overrun_d = 1'b1;
        if (i_accept) begin
          pend_d[ptr_q] = 1'b0;
          if (pend_d == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered output byte: the lane buffer (including this cycle's capture)
  // or the fill byte for a lane that never answered.
  always_comb begin
    valid_d = 1'b0;
    data_d  = data_q;
    busy_d  = (state_d != IDLE);
    if ((state_d == SEND) && pend_any) begin
      valid_d = 1'b1;
      data_d  = got_d[ptr_d] ? lane_buf_d[ptr_d] : FILL;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      got_q     <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      for (int n = 0; n < N_LANES; n++) lane_buf_q[n] <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      got_q      <= got_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      lane_buf_q <= lane_buf_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_overrun = overrun_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_x_rsp_collect.sv
// Testbench for x_rsp_collect: directed scenarios plus randomized
// transactions checked against a transaction-level model of the collector.
module tb_x_rsp_collect;
  import x_sram_pkg::*;

  localparam int unsigned TO   = 8;
  localparam logic [7:0]  FILLB = 8'hEE;
  localparam int          NEVER = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue;
  logic [15:0] mask;
  logic [15:0] ready;
  logic [7:0]  rd [16];
  logic        valid;
  logic [7:0]  data;
  logic        accept;
  logic        busy, done, overrun, timeout;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  always #5 clk = ~clk;

  x_rsp_collect #(.TIMEOUT(TO), .FILL(FILLB), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_issue(issue), .i_mask(mask), .i_ready(ready),
    .i_rdata_0(rd[0]), .i_rdata_1(rd[1]), .i_rdata_2(rd[2]), .i_rdata_3(rd[3]),
    .i_rdata_4(rd[4]), .i_rdata_5(rd[5]), .i_rdata_6(rd[6]), .i_rdata_7(rd[7]),
    .i_rdata_8(rd[8]), .i_rdata_9(rd[9]), .i_rdata_A(rd[10]), .i_rdata_B(rd[11]),
    .i_rdata_C(rd[12]), .i_rdata_D(rd[13]), .i_rdata_E(rd[14]), .i_rdata_F(rd[15]),
    .o_valid(valid), .o_data(data), .i_accept(accept), .o_busy(busy),
    .o_done(done), .o_overrun(overrun), .o_timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction description: strobe cycle (relative to the first COLLECT
  // cycle) and byte per lane, optional duplicate strobe, optional strobe on
  // an unmasked lane, optional stray issue while busy.
  logic [15:0] t_mask;
  int          st [16];
  logic [7:0]  dv [16];
  int          dup_c [16];
  logic [7:0]  dup_d [16];
  int          spur_lane, spur_c, iss_c;
  bit          iss_send;
  int          acc_mode;   // 0 random, 1 always, 2 toggle
  int          rst_after;  // bytes accepted before a mid-send reset, -1 none

  task automatic clear_sched();
    for (int n = 0; n < 16; n++) begin
      st[n] = NEVER; dv[n] = 8'h00; dup_c[n] = -1; dup_d[n] = 8'h00;
    end
    spur_lane = -1; spur_c = -1; iss_c = -1; iss_send = 1'b0;
    acc_mode = 1; rst_after = -1;
  endtask

  // Last COLLECT cycle: the cycle the final expected lane arrives, or the
  // end of the timeout window if some lane never arrives inside it.
  function automatic int calc_end();
    int e = 0;
    for (int n = 0; n < 16; n++) begin
      if (t_mask[n]) begin
        if (st[n] > int'(TO) - 1) return int'(TO) - 1;
        if (st[n] > e) e = st[n];
      end
    end
    return e;
  endfunction

  task automatic gen_random();
    int e;
    clear_sched();
    do begin
      t_mask = 16'($urandom);
      if ($urandom_range(0, 1) == 1) t_mask = t_mask & 16'($urandom) & 16'($urandom);
    end while (t_mask == 16'h0);
    for (int n = 0; n < 16; n++) begin
      dv[n] = 8'($urandom);
      if (t_mask[n]) st[n] = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
    end
    e = calc_end();
    for (int n = 0; n < 16; n++) begin
      if (t_mask[n] && st[n] < e && $urandom_range(0, 5) == 0) begin
        dup_c[n] = int'($urandom_range(st[n] + 1, e));
        dup_d[n] = 8'($urandom);
      end
    end
    if (t_mask != 16'hFFFF && $urandom_range(0, 5) == 0) begin
      do spur_lane = int'($urandom_range(0, 15)); while (t_mask[spur_lane]);
      spur_c = int'($urandom_range(0, e));
    end
    if ($urandom_range(0, 9) == 0) iss_c = int'($urandom_range(0, e));
    iss_send = ($urandom_range(0, 9) == 0);
    acc_mode = int'($urandom_range(0, 2));
  endtask

  task automatic run_txn(input string name);
    logic [7:0]  exp_q [$];
    int          e, idx, budget, tog;
    bit          exp_to, exp_ovr, acc;
    logic [15:0] rdy;

    e       = calc_end();
    exp_to  = 1'b0;
    exp_ovr = iss_send || (iss_c >= 0 && iss_c <= e) || (spur_c >= 0 && spur_c <= e);
    for (int n = 0; n < 16; n++) begin
      if (t_mask[n]) begin
        if (st[n] <= e) exp_q.push_back(dv[n]);
        else begin exp_q.push_back(FILLB); exp_to = 1'b1; end
        if (dup_c[n] > st[n] && dup_c[n] <= e) exp_ovr = 1'b1;
      end
    end

    @(negedge clk);
    chk({name, " idle_busy"}, 32'(busy), 32'd0);
    issue = 1'b1; mask = t_mask; ready = 16'($urandom);
    for (int n = 0; n < 16; n++) rd[n] = 8'($urandom);

    for (int c = 0; c <= e; c++) begin
      @(negedge clk);
      chk({name, " collect_busy"}, 32'(busy), 32'd1);
      chk({name, " collect_valid"}, 32'(valid), 32'd0);
      rdy = '0;
      for (int n = 0; n < 16; n++) begin
        rd[n] = 8'($urandom);
        if (t_mask[n] && st[n] == c) begin rdy[n] = 1'b1; rd[n] = dv[n]; end
        if (dup_c[n] == c) begin rdy[n] = 1'b1; rd[n] = dup_d[n]; end
      end
      if (spur_c == c) rdy[spur_lane] = 1'b1;
      ready = rdy;
      issue = (iss_c == c);
      mask  = 16'($urandom) | 16'h1;
    end

    @(negedge clk);
    ready = '0; issue = 1'b0;
    idx = 0; budget = 200; tog = 0;
    while (idx < exp_q.size() && budget > 0) begin
      chk({name, " send_valid"}, 32'(valid), 32'd1);
      chk({name, " send_data"}, 32'(data), 32'(exp_q[idx]));
      chk({name, " send_done"}, 32'(done), 32'd0);
      if (rst_after == idx) begin
        #2 rst = 1'b1;
        #1;
        chk({name, " rst_valid"}, 32'(valid), 32'd0);
        chk({name, " rst_busy"}, 32'(busy), 32'd0);
        chk({name, " rst_overrun"}, 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0; accept = 1'b0;
        return;
      end
      case (acc_mode)
        1:       acc = 1'b1;
        2:       acc = (tog % 2 == 0);
        default: acc = ($urandom_range(0, 1) == 1);
      endcase
      accept = acc;
      issue  = iss_send && (tog == 0);
      @(negedge clk);
      issue = 1'b0;
      if (acc) idx++;
      tog++;
      budget--;
    end
    accept = 1'b0;
    chk({name, " sent_count"}, 32'(idx), 32'(exp_q.size()));
    chk({name, " end_valid"}, 32'(valid), 32'd0);
    chk({name, " end_done"}, 32'(done), 32'd1);
    chk({name, " end_busy"}, 32'(busy), 32'd0);
    chk({name, " overrun"}, 32'(overrun), 32'(exp_ovr));
    chk({name, " timeout"}, 32'(timeout), 32'(exp_to));
    @(negedge clk);
    chk({name, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; issue = 1'b0; mask = '0; ready = '0; accept = 1'b0;
    for (int n = 0; n < 16; n++) rd[n] = 8'h00;
    #3 rst = 1'b1;
    #1;
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset data", 32'(data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset flags", {30'd0, overrun, timeout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Issue with an empty mask stays idle.
    @(negedge clk);
    issue = 1'b1; mask = 16'h0;
    @(negedge clk);
    issue = 1'b0;
    chk("mask0 busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("mask0 busy2", 32'(busy), 32'd0);

    clear_sched(); t_mask = 16'h0005;
    st[2] = 0; dv[2] = 8'hB2; st[0] = 1; dv[0] = 8'hA0;
    run_txn("two_lane");

    clear_sched(); t_mask = 16'hFFFF; acc_mode = 2;
    for (int n = 0; n < 16; n++) begin st[n] = 0; dv[n] = 8'(8'h10 + n); end
    run_txn("all_lanes");

    clear_sched(); t_mask = 16'h0003; st[1] = 0; dv[1] = 8'h55;
    run_txn("timeout");

    clear_sched(); t_mask = 16'h0003;
    st[0] = 0; dv[0] = 8'h11; dup_c[0] = 1; dup_d[0] = 8'h22; st[1] = 2; dv[1] = 8'h33;
    run_txn("dup_strobe");

    clear_sched(); t_mask = 16'h0003; st[0] = 0; st[1] = 0; dv[0] = 8'h01; dv[1] = 8'h02;
    spur_lane = 5; spur_c = 0;
    run_txn("unmasked");

    clear_sched(); t_mask = 16'h0011; st[0] = 1; st[4] = 0; dv[0] = 8'hC0; dv[4] = 8'hC4;
    iss_send = 1'b1; acc_mode = 2;
    run_txn("issue_busy");

    clear_sched(); t_mask = 16'h0003; st[0] = 0; st[1] = 0; dv[0] = 8'h5A; dv[1] = 8'hA5;
    rst_after = 1;
    run_txn("mid_reset");

    clear_sched(); t_mask = 16'h8000; st[15] = 0; dv[15] = 8'h7F;
    run_txn("after_reset");

    for (int i = 0; i < 150; i++) begin
      gen_random();
      run_txn("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
